// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner of a shared UART TX engine, one requester per whole message.
// Optional: define UART_ARB_CRLF_EN to append CR/LF after every completed message.

module uart_tx_arbiter_lane #(
   parameter int IDX = 0,
   parameter int GW  = 2
) (
   input  logic          valid,
   input  logic          above_ptr,
   input  logic [GW-1:0] grant_id,
   input  logic          accept_en,
   output logic          hi_req,
   output logic          ready
);
   localparam logic [GW-1:0] ID = GW'(IDX);

   assign hi_req = valid & above_ptr;
   assign ready  = accept_en & valid & (grant_id == ID);
endmodule

module uart_tx_arbiter #(
   parameter int NREQ        = 4,
   parameter int GAP_TIMEOUT = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [8*NREQ-1:0]       req_data,
   input  logic [NREQ-1:0]         req_last,
   output logic [NREQ-1:0]         req_ready,
   output logic [7:0]              tx_data,
   output logic                    tx_start,
   input  logic                    tx_busy,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    locked
);
   localparam int              GW      = $clog2(NREQ);
   localparam logic [15:0]     GAP_T   = 16'(GAP_TIMEOUT);
   localparam logic [GW-1:0]   LAST_ID = GW'(NREQ-1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_START,
      S_ACK,
      S_DRAIN
`ifdef UART_ARB_CRLF_EN
      , S_CR,
      S_LF
`endif
   } state_t;

   state_t          state, nxt;
   logic [GW-1:0]   rr_ptr, pick, next_ptr;
   logic [NREQ-1:0] above_ptr, hi_req;
   logic [15:0]     gap, gap_nxt;
   logic            last_q, accept_en, acc_go, timeout;
   logic            do_grant, do_accept, do_release, gap_inc;
   logic [7:0]      sel_byte;
   logic            sel_last;

`ifdef UART_ARB_CRLF_EN
   typedef enum logic [1:0] {PH_DATA, PH_CR, PH_LF} phase_t;
   phase_t ph;
   logic   ld_cr, ld_lf;
`endif

   // Requesters at or above rr_ptr get first pick; the rest are the wrap-around.
   assign above_ptr = ~((NREQ'(1) << rr_ptr) - NREQ'(1));
   assign accept_en = (state == S_ACCEPT) && !tx_busy;
   assign acc_go    = |req_ready;
   assign sel_byte  = req_data[{grant_id, 3'b000} +: 8];
   assign sel_last  = req_last[grant_id];
   assign next_ptr  = (grant_id == LAST_ID) ? '0 : grant_id + GW'(1);
   assign gap_nxt   = (gap == 16'hFFFF) ? gap : gap + 16'd1;
   assign timeout   = (gap_nxt >= GAP_T);

   for (genvar i = 0; i < NREQ; i++) begin : g_lane
      uart_tx_arbiter_lane #(.IDX(i), .GW(GW)) u_lane (
         .valid     (req_valid[i]),
         .above_ptr (above_ptr[i]),
         .grant_id  (grant_id),
         .accept_en (accept_en),
         .hi_req    (hi_req[i]),
         .ready     (req_ready[i])
      );
   end

   always_comb begin
      pick = '0;
      for (int i = NREQ-1; i >= 0; i--)
         if (req_valid[i]) pick = GW'(i);
      if (|hi_req)
         for (int i = NREQ-1; i >= 0; i--)
            if (hi_req[i]) pick = GW'(i);
   end

`ifdef UART_ARB_CRLF_EN
   assign tx_start = (state == S_START) || (state == S_CR) || (state == S_LF);
`else
   assign tx_start = (state == S_START);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt        = state;
      do_grant   = 1'b0;
      do_accept  = 1'b0;
      do_release = 1'b0;
      gap_inc    = 1'b0;
`ifdef UART_ARB_CRLF_EN
      ld_cr      = 1'b0;
      ld_lf      = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (|req_valid) begin
               do_grant = 1'b1;
               nxt      = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            if (acc_go) begin
               do_accept = 1'b1;
               nxt       = S_START;
            end else if (timeout) begin
               do_release = 1'b1;
               nxt        = S_IDLE;
            end else begin
               gap_inc = 1'b1;
            end
         end
         S_START: nxt = S_ACK;
         // Engine raises busy one cycle after start, so this cycle must not look at it.
         S_ACK:   nxt = S_DRAIN;
         S_DRAIN: begin
            if (!tx_busy) begin
               if (!last_q) begin
                  nxt = S_ACCEPT;
`ifdef UART_ARB_CRLF_EN
               end else if (ph == PH_DATA) begin
                  ld_cr = 1'b1;
                  nxt   = S_CR;
               end else if (ph == PH_CR) begin
                  ld_lf = 1'b1;
                  nxt   = S_LF;
`endif
               end else begin
                  do_release = 1'b1;
                  nxt        = S_IDLE;
               end
            end
         end
`ifdef UART_ARB_CRLF_EN
         S_CR:    nxt = S_ACK;
         S_LF:    nxt = S_ACK;
`endif
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_id <= '0;
         locked   <= 1'b0;
         rr_ptr   <= '0;
         gap      <= '0;
         tx_data  <= 8'h00;
         last_q   <= 1'b0;
      end else begin
         if (do_grant) begin
            grant_id <= pick;
            locked   <= 1'b1;
         end
         if (do_release) begin
            locked <= 1'b0;
            rr_ptr <= next_ptr;
         end
         if (do_accept) begin
            tx_data <= sel_byte;
            last_q  <= sel_last;
         end
         if (do_accept || state == S_IDLE) gap <= '0;
         else if (gap_inc)                 gap <= gap_nxt;
`ifdef UART_ARB_CRLF_EN
         if (ld_cr) tx_data <= 8'h0D;
         if (ld_lf) tx_data <= 8'h0A;
`endif
      end
   end

`ifdef UART_ARB_CRLF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         ph <= PH_DATA;
      else if (do_accept) ph <= PH_DATA;
      else if (ld_cr)     ph <= PH_CR;
      else if (ld_lf)     ph <= PH_LF;
   end
`endif
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter between `NREQ` on-chip requesters, such as debug printers and status reporters, so their console lines never interleave. A requester wins the transmitter by round-robin, keeps it for a whole message (up to its `req_last` byte) and hands it back. The block sits between the requesters and the byte-level UART TX engine, whose serial output drives `TX` at 115200 baud. It paces bytes with the engine's `tx_busy` handshake.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `GAP_TIMEOUT`, 1024: idle cycles of the granted requester before its grant is revoked; 16-bit counter.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  requester i has a byte on `req_data[8*i+7:8*i]`.
- `req_data`  in  8*NREQ  packed bytes.
- `req_last`  in  NREQ  current byte of requester i ends its message.
- `req_ready`  out  NREQ  one-cycle accept pulse; the byte transfers when valid and ready are both high.
- `tx_data`  out  8  byte to the UART engine; valid while `tx_start` is high.
- `tx_start`  out  1  one-cycle start pulse to the engine.
- `tx_busy`  in  1  engine frame in progress; rises the cycle after `tx_start` and falls after the stop bit.
- `grant_id`  out  $clog2(NREQ)  current owner; holds its last value when idle.
- `locked`  out  1  a message is in progress.

## Operation
- States: IDLE, ACCEPT, START, ACK, DRAIN, and CR and LF when the macro is defined.
- IDLE
  - If any `req_valid` is high, pick the first requester at or after `rr_ptr`, scanning upward and wrapping.
  - Register it into `grant_id`, set `locked`, go to ACCEPT.
  - With no requests, stay in IDLE.
- ACCEPT
  - If `req_valid[grant_id]` and `!tx_busy`: pulse `req_ready[grant_id]`, capture the data byte and the last flag, clear the gap counter, go to START.
  - Otherwise increment the gap counter, saturating.
  - When the counter reaches `GAP_TIMEOUT`: release the grant, set `rr_ptr = grant_id+1` modulo NREQ, go to IDLE. No CR/LF is sent.
- START: drive `tx_start=1` with the captured byte on `tx_data`, go to ACK.
- ACK: single wait cycle covering the engine's start-to-busy latency; `tx_busy` is ignored here. Go to DRAIN.
- DRAIN: wait for `tx_busy=0`. Then:
  - captured last flag clear: go to ACCEPT;
  - flag set: go to CR if the macro is defined, else release.
- Release: clear `locked`, set `rr_ptr = grant_id+1` modulo NREQ, go to IDLE.
- Fairness rules:
  - Non-owners never see `req_ready` while `locked` is high.
  - A requester that re-requests immediately after its release waits behind every other pending requester.
- Requester data must stay stable while `req_valid` is high and `req_ready` is low.

## Timing
- Reset values: `req_ready=0`, `tx_start=0`, `tx_data=8'h00`, `grant_id=0`, `locked=0`, `rr_ptr=0`, gap counter 0, state IDLE.
- Reset mid-operation: outputs return to reset values immediately. An engine frame already in flight is not aborted by this block.
- Latency: `req_valid` high in IDLE at cycle N gives `grant_id`/`locked` at N+1, `req_ready` at N+1 (engine idle) and `tx_start` at N+2.
- Per byte: ACCEPT, START, ACK, then DRAIN for the frame duration, then the next ACCEPT the cycle after `tx_busy` falls.
- Only one `req_ready` bit is ever high, for exactly one cycle per byte.
- `tx_start` is never asserted while `tx_busy` is high.
- Simultaneous requests resolve by `rr_ptr` order in the same IDLE cycle.
- Single-byte message (valid with last): one byte, then release.

## Configuration
- `UART_ARB_CRLF_EN`
  - Defined: after a message's last byte drains, CR sends 8'h0D and LF sends 8'h0A. Each uses its own START/ACK/DRAIN sequence with the grant still held, then release. The console therefore prints each message as one line.
  - Undefined: CR/LF states are absent; release happens straight after the last byte's DRAIN.

## Test plan
- Requester 0 sends "AB", last on 'B', engine busy 10 cycles per byte -> `tx_data` sequence 8'h41, 8'h42 (plus 8'h0D, 8'h0A with the macro), exactly two `req_ready[0]` pulses, `locked` low after the final drain.
- Requesters 0 and 2 both raise valid in IDLE with `rr_ptr=0` -> requester 0's message completes entirely before requester 2 gets its first `req_ready`; then `rr_ptr=3`.
- Requester 1 raises valid in the middle of requester 3's 4-byte message -> no `req_ready[1]` until requester 3's release, and no interleaved bytes on `tx_data`.
- Requester 0 sends one byte without last, then drops valid; `GAP_TIMEOUT=16` -> grant released 16 cycles after entering ACCEPT, no CR/LF, waiting requester 1 granted the next cycle.
- `rst_n` low during DRAIN -> all outputs 0 asynchronously; after release, a new request gets `req_ready` one cycle after IDLE detects it.
- `tx_busy` held high at the ACCEPT entry -> `req_ready` withheld until `tx_busy` falls; `tx_start` never overlaps `tx_busy`.
